// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_mem_slave.
interface ahb_mem_slave_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  hsel_i;
    logic [HADDR_SIZE-1:0] haddr_i;
    logic [1:0]            htrans_i;
    logic                  hwrite_i;
    logic [2:0]            hsize_i;
    logic [2:0]            hburst_i;
    logic                  hready_i;
    logic [HDATA_SIZE-1:0] hwdata_i;
    logic                  hreadyout_o;
    logic                  hresp_o;
    logic [HDATA_SIZE-1:0] hrdata_o;

    modport slave (
        input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hready_i, hwdata_i,
        output hreadyout_o, hresp_o, hrdata_o
    );

    modport master (
        output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hready_i, hwdata_i,
        input  hreadyout_o, hresp_o, hrdata_o
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave with optional wait states and write-to-read forwarding.
// Define AHB_MEM_SLAVE_ERR_EN to enable two-cycle ERROR responses for bad index/size.
module ahb_mem_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic           hclk,
    input  logic           hresetn,
    ahb_mem_slave_if.slave bus
);
    localparam int BYTES = HDATA_SIZE / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);

`ifdef AHB_MEM_SLAVE_ERR_EN
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

    state_t                state, nxt;
    logic [2:0]            cnt;
    logic                  pend, pwrite;
    logic [IDXW-1:0]       pidx, aidx;
    logic [OFFW-1:0]       poff;
    logic [2:0]            psize, hsize_eff;
    logic [HDATA_SIZE-1:0] rdata, wmerge;
    logic [BYTES-1:0]      be;
    logic                  ready, resp, accept, accept_ok, err, commit;

    logic [HDATA_SIZE-1:0] mem [DEPTH];

    assign aidx      = bus.haddr_i[OFFW +: IDXW];
    assign hsize_eff = (bus.hsize_i > 3'(OFFW)) ? 3'(OFFW) : bus.hsize_i;
    assign accept    = bus.hsel_i && bus.hready_i && bus.htrans_i[1] && ready;
    assign accept_ok = accept && !err;
    // A pending write retires in the first ready cycle of its data phase.
    assign commit    = pend && pwrite && ready;

`ifdef AHB_MEM_SLAVE_ERR_EN
    assign err   = ((bus.haddr_i >> (OFFW + IDXW)) != '0) || (bus.hsize_i > 3'(OFFW));
    assign ready = (state == IDLE) || (state == ERR2);
    assign resp  = (state == ERR1) || (state == ERR2);
`else
    assign err   = 1'b0;
    assign ready = (state == IDLE);
    assign resp  = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            WAIT: if (cnt == 3'd0) nxt = IDLE;
`ifdef AHB_MEM_SLAVE_ERR_EN
            ERR1: nxt = ERR2;
            ERR2: nxt = IDLE;
`endif
            default: ;
        endcase
        if (accept_ok) nxt = (WAIT_STATES > 0) ? WAIT : IDLE;
`ifdef AHB_MEM_SLAVE_ERR_EN
        if (accept && err) nxt = ERR1;
`endif
    end

    // Byte lane b is enabled when it lies in the same size-aligned block as the offset.
    always_comb begin
        be = '0;
        for (int b = 0; b < BYTES; b++)
            be[b] = ((b >> psize) == (int'(poff) >> psize));
    end

    always_comb begin
        wmerge = mem[pidx];
        for (int b = 0; b < BYTES; b++)
            if (be[b]) wmerge[8*b +: 8] = bus.hwdata_i[8*b +: 8];
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state <= IDLE;
            cnt   <= 3'd0;
            pend  <= 1'b0;
            rdata <= '0;
        end else begin
            state <= nxt;
            if (accept_ok && WAIT_STATES > 0)
                cnt <= 3'(WAIT_STATES - 1);
            else if (state == WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;
            if (ready)
                pend <= accept_ok;
            if (accept_ok && !bus.hwrite_i)
                rdata <= (commit && pidx == aidx) ? wmerge : mem[aidx];
        end
    end

    always_ff @(posedge hclk) begin
        if (accept_ok) begin
            pidx   <= aidx;
            poff   <= bus.haddr_i[OFFW-1:0];
            psize  <= hsize_eff;
            pwrite <= bus.hwrite_i;
        end
    end

    // Memory has no reset; a reset edge blocks the commit of an in-flight write.
    always_ff @(posedge hclk) begin
        if (hresetn && commit)
            for (int b = 0; b < BYTES; b++)
                if (be[b]) mem[pidx][8*b +: 8] <= bus.hwdata_i[8*b +: 8];
    end

    assign bus.hreadyout_o = ready;
    assign bus.hresp_o     = resp;
    assign bus.hrdata_o    = rdata;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomized bench for ahb_mem_slave: two instances (0 and 3 wait states) vs a byte-level memory model.
module tb_ahb_mem_slave;
    localparam int DEPTH = 1024;
    localparam int NW    = 64;
    localparam int WS1   = 3;

    typedef struct {
        bit          sel;
        bit [1:0]    trans;
        bit          wr;
        logic [31:0] addr;
        bit [2:0]    size;
        logic [31:0] wdata;
    } xfer_t;

    logic hclk = 1'b0;
    logic rst0_n, rst1_n;
    always #5 hclk = ~hclk;

    ahb_mem_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) b0 ();
    ahb_mem_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) b1 ();
    assign b0.hready_i = b0.hreadyout_o;
    assign b1.hready_i = b1.hreadyout_o;

    ahb_mem_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .DEPTH(DEPTH), .WAIT_STATES(0))
        u0 (.hclk(hclk), .hresetn(rst0_n), .bus(b0));
    ahb_mem_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .DEPTH(DEPTH), .WAIT_STATES(WS1))
        u1 (.hclk(hclk), .hresetn(rst1_n), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] refm [2][DEPTH];
    xfer_t q[$];
    logic [31:0] last_rd;
    int last_lows;
    int lows_total;

    function automatic xfer_t mk(input bit wr, input logic [31:0] addr, input bit [2:0] size,
                                 input logic [31:0] wdata);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        return x;
    endfunction

    function automatic xfer_t mk_idle();
        xfer_t x;
        x = mk(1'b0, 32'h0, 3'd2, 32'h0);
        x.trans = 2'b00;
        return x;
    endfunction

    function automatic bit exp_err(input xfer_t x);
`ifdef AHB_MEM_SLAVE_ERR_EN
        return (x.addr / 4 >= DEPTH) || (x.size > 3'd2);
`else
        return (x.addr === 32'hx);
`endif
    endfunction

    task automatic drive(input int d, input xfer_t x);
        b0.hsel_i = (d == 0) && x.sel;
        b1.hsel_i = (d == 1) && x.sel;
        b0.haddr_i = x.addr;  b1.haddr_i = x.addr;
        b0.htrans_i = x.trans; b1.htrans_i = x.trans;
        b0.hwrite_i = x.wr;   b1.hwrite_i = x.wr;
        b0.hsize_i = x.size;  b1.hsize_i = x.size;
        b0.hburst_i = 3'($urandom_range(0, 7));
        b1.hburst_i = b0.hburst_i;
    endtask

    task automatic set_wdata(input logic [31:0] w);
        b0.hwdata_i = w;
        b1.hwdata_i = w;
    endtask

    // Reference memory: update only the bytes the transfer size covers.
    task automatic model_write(input int d, input xfer_t x);
        int idx, n, lo;
        idx = int'((x.addr / 4) % DEPTH);
        n   = 1 << x.size;
        lo  = int'(x.addr % 4);
        for (int k = 0; k < n; k++)
            refm[d][idx][8*(lo+k) +: 8] = x.wdata[8*(lo+k) +: 8];
    endtask

    // Pipelined master: address phase of the head of q overlaps the current data phase.
    task automatic run_q(input int d);
        xfer_t ap, dp;
        bit dp_v;
        int lows, guard, idx;
        logic r, rs;
        logic [31:0] rd, expv;
        bit e;
        dp_v = 0; lows = 0; guard = 0;
        while ((q.size() > 0 || dp_v) && guard < 5000) begin
            guard++;
            ap = (q.size() > 0) ? q[0] : mk_idle();
            drive(d, ap);
            set_wdata((dp_v && dp.wr) ? dp.wdata : $urandom);
            @(negedge hclk);
            r  = d ? b1.hreadyout_o : b0.hreadyout_o;
            rs = d ? b1.hresp_o     : b0.hresp_o;
            rd = d ? b1.hrdata_o    : b0.hrdata_o;
            if (dp_v) begin
                e = exp_err(dp);
                n_cmp++;
                if (rs !== e) begin
                    n_bad++;
                    $display("FAIL hresp dut%0d addr %h: got %b want %b", d, dp.addr, rs, e);
                end
                if (r !== 1'b1) begin
                    lows++;
                    lows_total++;
                end else begin
                    n_cmp++;
                    if (lows != (e ? 1 : (d ? WS1 : 0))) begin
                        n_bad++;
                        $display("FAIL wait_cycles dut%0d addr %h: got %0d want %0d", d, dp.addr, lows,
                                 e ? 1 : (d ? WS1 : 0));
                    end
                    last_lows = lows;
                    if (!e) begin
                        if (dp.wr) model_write(d, dp);
                        else begin
                            idx  = int'((dp.addr / 4) % DEPTH);
                            expv = refm[d][idx];
                            n_cmp++;
                            if (rd !== expv) begin
                                n_bad++;
                                $display("FAIL rdata dut%0d addr %h: got %h want %h", d, dp.addr, rd, expv);
                            end
                            last_rd = rd;
                        end
                    end
                end
            end else begin
                n_cmp++;
                if (r !== 1'b1 || rs !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_ready dut%0d: got ready %b resp %b want 1 0", d, r, rs);
                end
            end
            @(posedge hclk); #1;
            if (r === 1'b1) begin
                dp_v = 0;
                lows = 0;
                if (q.size() > 0) begin
                    ap = q.pop_front();
                    if (ap.sel && ap.trans[1]) begin
                        dp = ap;
                        dp_v = 1;
                    end
                end
            end
        end
        if (guard >= 5000) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout dut%0d: got no completion within %0d cycles want completion", d, guard);
            q.delete();
        end
        drive(d, mk_idle());
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst0_n = 1'b0; rst1_n = 1'b0;
        drive(0, mk_idle());
        set_wdata(32'h0);
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_ready0", {31'b0, b0.hreadyout_o}, 32'd1);
        chk("reset_resp0",  {31'b0, b0.hresp_o},     32'd0);
        chk("reset_rdata0", b0.hrdata_o,             32'd0);
        chk("reset_ready1", {31'b0, b1.hreadyout_o}, 32'd1);
        chk("reset_resp1",  {31'b0, b1.hresp_o},     32'd0);
        chk("reset_rdata1", b1.hrdata_o,             32'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(posedge hclk); #1;
    endtask

    task automatic test_init(input int d);
        for (int i = 0; i < NW; i++) q.push_back(mk(1'b1, 32'(i * 4), 3'd2, $urandom));
        run_q(d);
    endtask

    task automatic test_word_rw();
        lows_total = 0;
        q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        run_q(0);
        chk("word_rw_rdata", last_rd, 32'hDEADBEEF);
        chk("word_rw_no_wait", 32'(lows_total), 32'd0);
    endtask

    task automatic test_byte_write(input int d);
        q.push_back(mk(1'b1, 32'h10, 3'd2, 32'h11223344));
        q.push_back(mk(1'b1, 32'h13, 3'd0, 32'hAA000000));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        run_q(d);
        chk("byte_write", last_rd, 32'hAA223344);
    endtask

    task automatic test_wait_states();
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        run_q(1);
        chk("wait_states_low", 32'(last_lows), 32'd3);
    endtask

    task automatic test_back_to_back(input int d);
        q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h12345678));
        q.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
        run_q(d);
        chk("back_to_back_fwd", last_rd, 32'h12345678);
    endtask

    task automatic test_addr_range(input int d);
        xfer_t x;
        q.push_back(mk(1'b1, 32'h0, 3'd2, 32'h0BADF00D));
        q.push_back(mk(1'b1, 32'h1000, 3'd2, 32'hCAFEF00D));
`ifdef AHB_MEM_SLAVE_ERR_EN
        x = mk(1'b0, 32'h0, 3'd3, 32'h0);
        q.push_back(x);
        q.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
        run_q(d);
        chk("err_index0_kept", last_rd, 32'h0BADF00D);
`else
        x = mk(1'b0, 32'h0, 3'd2, 32'h0);
        q.push_back(x);
        run_q(d);
        chk("wrap_index0", last_rd, 32'hCAFEF00D);
`endif
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] old;
        xfer_t x;
        old = refm[1][16];
        x = mk(1'b1, 32'h40, 3'd2, 32'h0);
        drive(1, x);
        set_wdata(~old);
        @(posedge hclk); #1;
        drive(1, mk_idle());
        @(posedge hclk); #1;
        chk("midwrite_waiting", {31'b0, b1.hreadyout_o}, 32'd0);
        rst1_n = 1'b0;
        @(posedge hclk); #1;
        chk("midwrite_rst_ready", {31'b0, b1.hreadyout_o}, 32'd1);
        chk("midwrite_rst_resp",  {31'b0, b1.hresp_o},     32'd0);
        chk("midwrite_rst_rdata", b1.hrdata_o,             32'd0);
        rst1_n = 1'b1;
        @(posedge hclk); #1;
        q.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0));
        run_q(1);
        chk("midwrite_mem_kept", last_rd, old);
    endtask

    task automatic test_random(input int d);
        for (int i = 0; i < 200; i++) begin
            xfer_t x;
            int r, idx;
            bit [2:0] sz;
            logic [31:0] a;
            r   = $urandom_range(0, 19);
            idx = $urandom_range(0, NW - 1);
            sz  = 3'($urandom_range(0, 2));
            a   = 32'(idx * 4) + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            x   = mk(1'($urandom_range(0, 1)), a, sz, $urandom);
            if (r == 0) x.trans = 2'($urandom_range(0, 1));
            else if (r == 1) x.sel = 1'b0;
            else x.trans = 2'($urandom_range(2, 3));
            q.push_back(x);
        end
        run_q(d);
    endtask

    initial begin
        test_reset();
        test_init(0);
        test_init(1);
        test_word_rw();
        test_byte_write(0);
        test_byte_write(1);
        test_wait_states();
        test_back_to_back(0);
        test_back_to_back(1);
        test_addr_range(0);
        test_addr_range(1);
        test_reset_midwrite();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, AHB data width; legal values are 32 and 64.
REQ-003 SHALL have parameter DEPTH, default 1024, number of HDATA_SIZE words; power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 0, HREADYOUT-low cycles per transfer; range 0..7.
REQ-005 SHALL have port hclk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port hresetn, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port hsel_i, input, 1, slave select.
REQ-008 SHALL have port haddr_i, input, HADDR_SIZE, byte address.
REQ-009 SHALL have port htrans_i, input, 2, transfer type.
REQ-010 SHALL have port hwrite_i, input, 1, 1 = write.
REQ-011 SHALL have port hsize_i, input, 3, transfer size.
REQ-012 SHALL have port hburst_i, input, 3, burst type; accepted and ignored.
REQ-013 SHALL have port hready_i, input, 1, bus HREADY.
REQ-014 SHALL have port hwdata_i, input, HDATA_SIZE, write data.
REQ-015 SHALL have port hreadyout_o, output, 1, slave ready.
REQ-016 SHALL have port hresp_o, output, 1, 0 = OKAY, 1 = ERROR.
REQ-017 SHALL have port hrdata_o, output, HDATA_SIZE, read data.

Function
REQ-018 Address phase SHALL be accepted only when hsel_i=1, hready_i=1 and htrans_i is NONSEQ or SEQ; IDLE/BUSY SHALL get a zero-wait OKAY.
REQ-019 On acceptance the block SHALL register the word index, byte offset, hsize and hwrite.
REQ-020 FSM states: IDLE, WAIT, ERR1, ERR2; on acceptance IDLE->WAIT if WAIT_STATES>0, otherwise it SHALL stay in IDLE with the data phase completing next cycle.
REQ-021 WAIT SHALL hold hreadyout_o=0 for exactly WAIT_STATES cycles using a down-counter, then return to IDLE with hreadyout_o=1.
REQ-022 Reads SHALL use a synchronous memory read issued at the acceptance edge; hrdata_o is valid in the cycle hreadyout_o=1 and is held stable during wait states.
REQ-023 Writes SHALL sample hwdata_i in the data-phase cycle with hreadyout_o=1 and commit at that edge using byte enables derived from hsize and the address LSBs (byte, half, word, dword).
REQ-024 Read-after-write to the same word index, accepted at the edge where the write commits, SHALL return the merged new bytes through a forwarding path, never stale data.
REQ-025 hsize greater than log2(HDATA_SIZE/8) SHALL be treated as an error per REQ-033, or ignored when that option is compiled out.
REQ-026 A word index wraps modulo DEPTH: upper address bits above the index SHALL be ignored unless REQ-033 applies.
REQ-027 A new address phase SHALL be accepted in the same cycle a previous data phase completes (back-to-back pipelining).

Reset
REQ-028 hresetn=0 sampled at an edge SHALL force: state IDLE, wait counter 0, pending write cleared, hreadyout_o=1, hresp_o=0, hrdata_o=0.
REQ-029 Reset asserted mid-transfer SHALL abort it; an uncommitted write SHALL not modify memory.
REQ-030 Memory contents SHALL not be cleared by reset.

Configuration
REQ-031 Macro AHB_MEM_SLAVE_ERR_EN SHALL select the error-response feature.
REQ-032 Without the macro, hresp_o SHALL be tied to 0, and ERR1/ERR2 SHALL be absent.
REQ-033 With the macro, an accepted transfer whose address index is at or above DEPTH, or whose hsize is illegal, SHALL give a two-cycle ERROR: ERR1 with hreadyout_o=0, hresp_o=1, then ERR2 with hreadyout_o=1, hresp_o=1, then IDLE; memory SHALL be unchanged.

Verification
REQ-034 Write word 0xDEADBEEF to 0x10, WAIT_STATES=0, then read 0x10 -> hreadyout_o is never low and hrdata_o=0xDEADBEEF.
REQ-035 Byte write 0xAA to 0x13 over 0x11223344, then read 0x10 -> 0xAA223344.
REQ-036 With WAIT_STATES=3, a read -> hreadyout_o low for exactly 3 cycles, with data valid on the 4th.
REQ-037 Back-to-back write 0x12345678 to 0x20 then read 0x20 -> read returns 0x12345678 via forwarding.
REQ-038 With AHB_MEM_SLAVE_ERR_EN and DEPTH=1024, access to 0x1000 -> ERR1 (hreadyout_o=0, hresp_o=1), then ERR2 (hreadyout_o=1, hresp_o=1); a subsequent read of index 0 is unchanged.
REQ-039 With WAIT_STATES=3, assert hresetn=0 during the second wait cycle of a write to 0x40 -> outputs return to reset values next edge, and 0x40 keeps its old value.
